tof_mod_gen_mc: RTL and testbench

TOF_MOD_GEN_MC -- requirements
Module: tof_mod_gen_mc

---
 rtl/tof_mod_gen_mc.sv | 204 ++++++++++++++++++++
 tb/tb_tof_mod_gen_mc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tof_mod_gen_mc.sv
// -----------------------------------------------------------------------------
// tof_mod_gen_mc
// Multi-channel time-of-flight modulation generator. A shared master counter
// sets the modulation period. Each channel waits out its own start delay and
// then produces a pulse train with its own high time. Runs are either
// continuous or limited to a burst of whole periods. Period and duty can be
// reloaded during a run; the new values take effect at a master wrap, so the
// waveform changes only on a period boundary.
//
// Ports
//   CLKIN    in   1        clock, rising edge
//   RST      in   1        asynchronous active-high reset
//   VALID    in   1        run enable; low aborts to idle
//   LOAD     in   1        pulse: stage PERIOD/DUTY as pending while running
//   PERIOD   in   CW       modulation period in CLKIN cycles
//   DUTY     in   N_CH*CW  per-channel high time, channel i at [i*CW +: CW]
//   DELAY    in   N_CH*CW  per-channel start delay, channel i at [i*CW +: CW]
//   BURST    in   CW       number of periods to emit, 0 = continuous
//   CLKOUT   out  N_CH     registered modulation outputs
//   BUSY     out  1        high while running
//   DONE     out  1        one-cycle pulse at burst completion
//   CFG_ERR  out  1        sticky: a zero period was refused
//
// State table
//   state    | meaning
//   S_IDLE   | outputs low, waiting for VALID with a non-zero PERIOD
//   S_RUN    | generating; master and channel counters advance
//   S_FINISH | one cycle after the burst completes; DONE high
// -----------------------------------------------------------------------------
module tof_mod_gen_mc #(
   parameter int N_CH = 4,
   parameter int CW   = 16
) (
   input  logic               CLKIN,
   input  logic               RST,
   input  logic               VALID,
   input  logic               LOAD,
   input  logic [CW-1:0]      PERIOD,
   input  logic [N_CH*CW-1:0] DUTY,
   input  logic [N_CH*CW-1:0] DELAY,
   input  logic [CW-1:0]      BURST,
   output logic [N_CH-1:0]    CLKOUT,
   output logic               BUSY,
   output logic               DONE,
   output logic               CFG_ERR
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

   localparam logic [CW-1:0] ONE = CW'(1);

   state_t                   state_q, state_d;
   logic [CW-1:0]            per_q, per_d;
   logic [CW-1:0]            mst_q, mst_d;
   logic [CW-1:0]            pcnt_q, pcnt_d;
   logic [CW-1:0]            burst_q, burst_d;
   logic [CW-1:0]            pper_q, pper_d;
   logic [N_CH-1:0][CW-1:0]  duty_q, duty_d;
   logic [N_CH-1:0][CW-1:0]  pduty_q, pduty_d;
   logic [N_CH-1:0][CW-1:0]  dly_q, dly_d;
   logic [N_CH-1:0][CW-1:0]  loc_q, loc_d;
   logic                     pend_q, pend_d;
   logic                     err_q, err_d;
   logic [N_CH-1:0]          out_q, out_d;
   logic                     wrap;
   logic [N_CH-1:0]          ch_out;

   always_ff @(posedge CLKIN or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         per_q   <= '0;
         mst_q   <= '0;
         pcnt_q  <= '0;
         burst_q <= '0;
         pper_q  <= '0;
         duty_q  <= '0;
         pduty_q <= '0;
         dly_q   <= '0;
         loc_q   <= '0;
         pend_q  <= 1'b0;
         err_q   <= 1'b0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         mst_q   <= mst_d;
         pcnt_q  <= pcnt_d;
         burst_q <= burst_d;
         pper_q  <= pper_d;
         duty_q  <= duty_d;
         pduty_q <= pduty_d;
         dly_q   <= dly_d;
         loc_q   <= loc_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
         out_q   <= out_d;
      end
   end

   always_comb begin
      state_d = state_q;
      per_d   = per_q;
      mst_d   = mst_q;
      pcnt_d  = pcnt_q;
      burst_d = burst_q;
      pper_d  = pper_q;
      duty_d  = duty_q;
      pduty_d = pduty_q;
      dly_d   = dly_q;
      loc_d   = loc_q;
      pend_d  = pend_q;
      err_d   = err_q;
      out_d   = '0;

      wrap = (mst_q == per_q - ONE);

      // A channel drives high only once its delay has fully elapsed. Since the
      // local counter never exceeds PERIOD-1, DUTY>=PERIOD means always high.
      ch_out = '0;
      for (int i = 0; i < N_CH; i++) begin
         ch_out[i] = (dly_q[i] == '0) && (loc_q[i] < duty_q[i]);
      end

      case (state_q)
         S_IDLE: begin
            if (VALID) begin
               if (PERIOD != '0) begin
                  per_d   = PERIOD;
                  duty_d  = DUTY;
                  dly_d   = DELAY;
                  burst_d = BURST;
                  mst_d   = '0;
                  pcnt_d  = '0;
                  loc_d   = '0;
                  pend_d  = 1'b0;
                  err_d   = 1'b0;
                  state_d = S_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_RUN: begin
            if (!VALID) begin
               pend_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               out_d = ch_out;
               mst_d = wrap ? '0 : mst_q + ONE;
               for (int i = 0; i < N_CH; i++) begin
                  if (dly_q[i] != '0) begin
                     dly_d[i] = dly_q[i] - ONE;
                  end else begin
                     loc_d[i] = (loc_q[i] == per_q - ONE) ? '0 : loc_q[i] + ONE;
                  end
               end
               if (wrap) begin
                  pcnt_d = pcnt_q + ONE;
                  // Channels still in their delay already hold a zero local
                  // count, so clearing all of them keeps every active channel
                  // phase-aligned to the master after a reload.
                  if (pend_q) begin
                     per_d  = pper_q;
                     duty_d = pduty_q;
                     loc_d  = '0;
                     pend_d = 1'b0;
                  end
                  if ((burst_q != '0) && (pcnt_q + ONE == burst_q)) begin
                     out_d   = '0;
                     pend_d  = 1'b0;
                     state_d = S_FINISH;
                  end
               end
               // Evaluated after the wrap so that a LOAD coinciding with the
               // wrap is staged for the following period instead of being lost.
               if (LOAD) begin
                  if (PERIOD != '0) begin
                     pper_d  = PERIOD;
                     pduty_d = DUTY;
                     pend_d  = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign CLKOUT  = out_q;
   assign BUSY    = (state_q == S_RUN);
   assign DONE    = (state_q == S_FINISH);
   assign CFG_ERR = err_q;

endmodule

// File: tb/tb_tof_mod_gen_mc.sv
// -----------------------------------------------------------------------------
// tb_tof_mod_gen_mc
// Directed testbench for tof_mod_gen_mc (N_CH=4, CW=16). E0 denotes the edge
// that samples VALID high in idle. Outputs are sampled 1 ns after each rising
// edge. The CLKOUT value seen after edge E0+1+c reflects master cycle c.
// -----------------------------------------------------------------------------
module tb_tof_mod_gen_mc;

   localparam int N_CH = 4;
   localparam int CW   = 16;

   logic               CLKIN;
   logic               RST;
   logic               VALID;
   logic               LOAD;
   logic [CW-1:0]      PERIOD;
   logic [N_CH*CW-1:0] DUTY;
   logic [N_CH*CW-1:0] DELAY;
   logic [CW-1:0]      BURST;
   logic [N_CH-1:0]    CLKOUT;
   logic               BUSY;
   logic               DONE;
   logic               CFG_ERR;

   int tests = 0;
   int fails = 0;

   tof_mod_gen_mc #(.N_CH(N_CH), .CW(CW)) dut (
      .CLKIN   (CLKIN),
      .RST     (RST),
      .VALID   (VALID),
      .LOAD    (LOAD),
      .PERIOD  (PERIOD),
      .DUTY    (DUTY),
      .DELAY   (DELAY),
      .BURST   (BURST),
      .CLKOUT  (CLKOUT),
      .BUSY    (BUSY),
      .DONE    (DONE),
      .CFG_ERR (CFG_ERR)
   );

   initial CLKIN = 1'b0;
   always #5 CLKIN = ~CLKIN;

   task automatic tick();
      @(posedge CLKIN);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hand-model of one channel: low for d cycles, then high for u of every p.
   function automatic logic ch_exp(input int c, input int d, input int u, input int p);
      if (c < d) return 1'b0;
      return ((c - d) % p) < u;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] e;

      RST    = 1'b1;
      VALID  = 1'b0;
      LOAD   = 1'b0;
      PERIOD = '0;
      DUTY   = '0;
      DELAY  = '0;
      BURST  = '0;
      tick();
      tick();
      chk("rst_clkout", 32'(CLKOUT), 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      chk("rst_done", 32'(DONE), 32'h0);
      chk("rst_cfg_err", 32'(CFG_ERR), 32'h0);
      RST = 1'b0;
      tick();
      chk("idle_no_valid_busy", 32'(BUSY), 32'h0);

      // Zero period refused, then a good period starts and clears the flag.
      VALID  = 1'b1;
      PERIOD = 16'd0;
      tick();
      chk("p0_busy", 32'(BUSY), 32'h0);
      chk("p0_cfg_err", 32'(CFG_ERR), 32'h1);
      tick();
      chk("p0_busy_hold", 32'(BUSY), 32'h0);
      PERIOD = 16'd5;
      DUTY   = {16'd0, 16'd0, 16'd0, 16'd2};
      tick();
      chk("p5_busy", 32'(BUSY), 32'h1);
      chk("p5_cfg_err_clr", 32'(CFG_ERR), 32'h0);
      VALID = 1'b0;
      tick();
      chk("p5_abort_busy", 32'(BUSY), 32'h0);
      chk("p5_abort_done", 32'(DONE), 32'h0);

      // Four channels with mixed delay/duty, continuous.
      PERIOD = 16'd8;
      DUTY   = {16'd8, 16'd0, 16'd4, 16'd1};
      DELAY  = {16'd0, 16'd5, 16'd3, 16'd0};
      BURST  = 16'd0;
      VALID  = 1'b1;
      tick();
      chk("mc_e0_clkout", 32'(CLKOUT), 32'h0);
      for (int c = 0; c < 24; c++) begin
         tick();
         e = {ch_exp(c, 0, 8, 8), ch_exp(c, 5, 0, 8), ch_exp(c, 3, 4, 8), ch_exp(c, 0, 1, 8)};
         chk($sformatf("mc_clkout_c%0d", c), 32'(CLKOUT), 32'(e));
         chk($sformatf("mc_busy_c%0d", c), 32'(BUSY), 32'h1);
      end
      // Abort while channel 3 is high.
      VALID = 1'b0;
      tick();
      chk("mc_abort_clkout", 32'(CLKOUT), 32'h0);
      chk("mc_abort_busy", 32'(BUSY), 32'h0);
      chk("mc_abort_done", 32'(DONE), 32'h0);

      // Burst of three periods.
      PERIOD = 16'd4;
      DUTY   = {16'd0, 16'd0, 16'd0, 16'd2};
      DELAY  = '0;
      BURST  = 16'd3;
      VALID  = 1'b1;
      tick();
      chk("burst_e0_busy", 32'(BUSY), 32'h1);
      for (int c = 0; c < 12; c++) begin
         tick();
         e = {3'b000, ((c % 4) < 2) && (c + 1 < 12)};
         chk($sformatf("burst_clkout_c%0d", c), 32'(CLKOUT), 32'(e));
         chk($sformatf("burst_busy_c%0d", c), 32'(BUSY), 32'(c + 1 < 12));
         chk($sformatf("burst_done_c%0d", c), 32'(DONE), 32'(c + 1 == 12));
      end
      VALID = 1'b0;
      tick();
      chk("burst_after_done", 32'(DONE), 32'h0);
      chk("burst_after_busy", 32'(BUSY), 32'h0);

      // Mid-run reloads: applied at wraps, last write wins, zero period refused.
      PERIOD = 16'd10;
      DUTY   = {16'd0, 16'd0, 16'd0, 16'd5};
      BURST  = 16'd0;
      VALID  = 1'b1;
      tick();
      for (int c = 0; c < 31; c++) begin
         LOAD = 1'b0;
         if (c == 3) begin
            LOAD = 1'b1; PERIOD = 16'd6; DUTY = {16'd0, 16'd0, 16'd0, 16'd2};
         end else if (c == 13) begin
            LOAD = 1'b1; PERIOD = 16'd7; DUTY = {16'd0, 16'd0, 16'd0, 16'd3};
         end else if (c == 14) begin
            LOAD = 1'b1; PERIOD = 16'd3; DUTY = {16'd0, 16'd0, 16'd0, 16'd1};
         end else if (c == 20) begin
            LOAD = 1'b1; PERIOD = 16'd0;
         end
         tick();
         if (c < 10)      e = {3'b000, c < 5};
         else if (c < 16) e = {3'b000, (c - 10) < 2};
         else             e = {3'b000, ((c - 16) % 3) < 1};
         chk($sformatf("reload_clkout_c%0d", c), 32'(CLKOUT), 32'(e));
         chk($sformatf("reload_cfg_err_c%0d", c), 32'(CFG_ERR), 32'(c >= 20));
      end
      LOAD  = 1'b0;
      VALID = 1'b0;
      tick();
      chk("reload_abort_clkout", 32'(CLKOUT), 32'h0);

      // Asynchronous reset in the middle of a run.
      PERIOD = 16'd4;
      DUTY   = {16'd0, 16'd0, 16'd0, 16'd4};
      VALID  = 1'b1;
      tick();
      LOAD   = 1'b1;
      PERIOD = 16'd0;
      tick();
      LOAD = 1'b0;
      chk("arst_pre_clkout", 32'(CLKOUT), 32'h1);
      chk("arst_pre_cfg_err", 32'(CFG_ERR), 32'h1);
      #2;
      RST = 1'b1;
      #1;
      chk("arst_clkout", 32'(CLKOUT), 32'h0);
      chk("arst_busy", 32'(BUSY), 32'h0);
      chk("arst_done", 32'(DONE), 32'h0);
      chk("arst_cfg_err", 32'(CFG_ERR), 32'h0);
      VALID = 1'b0;
      tick();
      RST = 1'b0;
      tick();
      chk("post_rst_idle_busy", 32'(BUSY), 32'h0);
      PERIOD = 16'd4;
      VALID  = 1'b1;
      tick();
      chk("post_rst_start_busy", 32'(BUSY), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
